pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: command sequencer that drives inc/add/sub pulses into an
// external program counter. Four-state FSM (IDLE, ISSUE, REPEAT, SETTLE),
// a separate halted flag and a sticky err flag. All outputs are registered.
// Optional feature: define PC_SEQ_CALL_EN to add CALL/RET with a 4-entry
// return stack. Without it, CALL/RET set err and otherwise act as NOP.
module pc_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [15:0] op_arg,
   input  logic [15:0] pc,
   output logic        op_ready,
   output logic        inc,
   output logic        add,
   output logic        sub,
   output logic [15:0] offset,
   output logic        halted,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_REPEAT, S_SETTLE} state_t;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_STEP   = 3'd1;
   localparam logic [2:0] OP_FWD    = 3'd2;
   localparam logic [2:0] OP_BACK   = 3'd3;
   localparam logic [2:0] OP_REPEAT = 3'd4;
   localparam logic [2:0] OP_HALT   = 3'd5;
   localparam logic [2:0] OP_CALL   = 3'd6;
   localparam logic [2:0] OP_RET    = 3'd7;

   state_t      r_state, w_state_next;
   logic [7:0]  r_rpt_cnt, w_rpt_cnt_next;
   logic        r_op_ready, w_op_ready_next;
   logic        r_inc, w_inc_next;
   logic        r_add, w_add_next;
   logic        r_sub, w_sub_next;
   logic [15:0] r_offset, w_offset_next;
   logic        r_halted, w_halted_next;
   logic        r_err, w_err_next;

   logic        w_accept;
   logic [16:0] w_fwd_sum;

   assign w_accept  = op_valid & r_op_ready;
   assign w_fwd_sum = {1'b0, pc} + {1'b0, op_arg};

`ifdef PC_SEQ_CALL_EN
   // Return stack: r_sp counts valid entries (0..4); top is r_stack[r_sp-1].
   logic [15:0] r_stack [0:3];
   logic [2:0]  r_sp, w_sp_next;
   logic        w_push;
   logic [15:0] w_ret_target;

   assign w_ret_target = r_stack[r_sp[1:0] - 2'd1];

   // Stack pointer; reset empties the stack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_sp <= 3'd0;
      else        r_sp <= w_sp_next;
   end

   // Stack storage; contents need no reset because r_sp guards every read.
   always_ff @(posedge clk) begin
      if (w_push) r_stack[r_sp[1:0]] <= pc + 16'd1;
   end
`endif

   // Next-state and next-output decode; outputs are registered from these.
   always_comb begin
      w_state_next   = r_state;
      w_rpt_cnt_next = r_rpt_cnt;
      w_inc_next     = 1'b0;
      w_add_next     = 1'b0;
      w_sub_next     = 1'b0;
      w_offset_next  = 16'd0;
      w_halted_next  = r_halted;
      w_err_next     = r_err;
`ifdef PC_SEQ_CALL_EN
      w_sp_next      = r_sp;
      w_push         = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (op)
                  OP_STEP: begin
                     w_state_next = S_ISSUE;
                     w_inc_next   = 1'b1;
                  end
                  OP_FWD: begin
                     w_state_next  = S_ISSUE;
                     w_add_next    = 1'b1;
                     w_offset_next = op_arg;
                     if (w_fwd_sum > 17'h0FFFF) w_err_next = 1'b1;
                  end
                  OP_BACK: begin
                     w_state_next  = S_ISSUE;
                     w_sub_next    = 1'b1;
                     w_offset_next = op_arg;
                     if (op_arg > pc) w_err_next = 1'b1;
                  end
                  OP_REPEAT: begin
                     // First pulse issues now; counter holds pulses still owed.
                     if (op_arg[7:0] != 8'd0) begin
                        w_state_next   = S_REPEAT;
                        w_inc_next     = 1'b1;
                        w_rpt_cnt_next = op_arg[7:0] - 8'd1;
                     end
                  end
                  OP_HALT: w_halted_next = 1'b1;
`ifdef PC_SEQ_CALL_EN
                  OP_CALL: begin
                     if (r_sp == 3'd4) begin
                        w_err_next = 1'b1;
                     end else begin
                        w_push        = 1'b1;
                        w_sp_next     = r_sp + 3'd1;
                        w_state_next  = S_ISSUE;
                        w_add_next    = 1'b1;
                        w_offset_next = op_arg;
                     end
                  end
                  OP_RET: begin
                     if (r_sp == 3'd0) begin
                        w_err_next = 1'b1;
                     end else begin
                        w_sp_next    = r_sp - 3'd1;
                        w_state_next = S_ISSUE;
                        if (w_ret_target >= pc) begin
                           w_add_next    = 1'b1;
                           w_offset_next = w_ret_target - pc;
                        end else begin
                           w_sub_next    = 1'b1;
                           w_offset_next = pc - w_ret_target;
                        end
                     end
                  end
`else
                  OP_CALL: w_err_next = 1'b1;
                  OP_RET:  w_err_next = 1'b1;
`endif
                  OP_NOP:  ;
                  default: ;
               endcase
            end
         end
         S_ISSUE:  w_state_next = S_SETTLE;
         S_REPEAT: begin
            if (r_rpt_cnt == 8'd0) begin
               w_state_next = S_SETTLE;
            end else begin
               w_inc_next     = 1'b1;
               w_rpt_cnt_next = r_rpt_cnt - 8'd1;
            end
         end
         S_SETTLE: w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
      w_op_ready_next = (w_state_next == S_IDLE) && !w_halted_next;
   end

   // State and output registers; reset drops pulses without waiting for clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_rpt_cnt  <= 8'd0;
         r_op_ready <= 1'b0;
         r_inc      <= 1'b0;
         r_add      <= 1'b0;
         r_sub      <= 1'b0;
         r_offset   <= 16'd0;
         r_halted   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_rpt_cnt  <= w_rpt_cnt_next;
         r_op_ready <= w_op_ready_next;
         r_inc      <= w_inc_next;
         r_add      <= w_add_next;
         r_sub      <= w_sub_next;
         r_offset   <= w_offset_next;
         r_halted   <= w_halted_next;
         r_err      <= w_err_next;
      end
   end

   assign op_ready = r_op_ready;
   assign inc      = r_inc;
   assign add      = r_add;
   assign sub      = r_sub;
   assign offset   = r_offset;
   assign halted   = r_halted;
   assign err      = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. Define PC_SEQ_CALL_EN to also
// exercise CALL/RET with the return stack.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [15:0] op_arg = 16'd0;
   logic [15:0] pc = 16'd0;
   logic        op_ready, inc, add, sub, halted, err;
   logic [15:0] offset;

   int n_checks = 0;
   int n_fail   = 0;

   pc_sequencer dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
      .op_arg(op_arg), .pc(pc), .op_ready(op_ready), .inc(inc),
      .add(add), .sub(sub), .offset(offset), .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] c, input logic [15:0] a, input logic [15:0] p);
      op_valid = 1'b1;
      op       = c;
      op_arg   = a;
      pc       = p;
      $display("cmd op=%0d arg=%h pc=%h t=%0t", c, a, p, $time);
   endtask

   initial begin
      // Reset: all outputs low while reset is held, ready at first edge after.
      #10;
      check("rst_inc", {15'd0, inc}, 16'd0);
      check("rst_add", {15'd0, add}, 16'd0);
      check("rst_sub", {15'd0, sub}, 16'd0);
      check("rst_offset", offset, 16'd0);
      check("rst_halted", {15'd0, halted}, 16'd0);
      check("rst_err", {15'd0, err}, 16'd0);
      check("rst_ready", {15'd0, op_ready}, 16'd0);
      #2.5 reset = 1'b1;
      tick();
      check("ready_after_rst", {15'd0, op_ready}, 16'd1);

      // STEP accepted at edge k: inc only in cycle k+1, ready low 2 cycles.
      send(3'd1, 16'd0, 16'd0);
      tick();
      op_valid = 1'b0;
      check("step_inc_k1", {15'd0, inc}, 16'd1);
      check("step_ready_k1", {15'd0, op_ready}, 16'd0);
      check("step_add_k1", {15'd0, add}, 16'd0);
      tick();
      check("step_inc_k2", {15'd0, inc}, 16'd0);
      check("step_ready_k2", {15'd0, op_ready}, 16'd0);
      tick();
      check("step_ready_k3", {15'd0, op_ready}, 16'd1);
      check("step_inc_k3", {15'd0, inc}, 16'd0);
      send(3'd1, 16'd0, 16'd1);
      tick();
      op_valid = 1'b0;
      check("step2_inc", {15'd0, inc}, 16'd1);
      tick();
      tick();
      check("step2_ready", {15'd0, op_ready}, 16'd1);

      // FWD 0x00A5 at pc=1: no overflow.
      send(3'd2, 16'h00A5, 16'h0001);
      tick();
      op_valid = 1'b0;
      check("fwd_add", {15'd0, add}, 16'd1);
      check("fwd_offset", offset, 16'h00A5);
      check("fwd_err", {15'd0, err}, 16'd0);
      check("fwd_inc", {15'd0, inc}, 16'd0);
      tick();
      check("fwd_add_off", {15'd0, add}, 16'd0);
      check("fwd_offset_off", offset, 16'd0);
      tick();
      check("fwd_ready", {15'd0, op_ready}, 16'd1);

      // BACK 0x0014 at pc=0x0010: underflow, err sticky.
      send(3'd3, 16'h0014, 16'h0010);
      tick();
      op_valid = 1'b0;
      check("back_sub", {15'd0, sub}, 16'd1);
      check("back_offset", offset, 16'h0014);
      check("back_err", {15'd0, err}, 16'd1);
      tick();
      check("back_sub_off", {15'd0, sub}, 16'd0);
      check("back_err_hold1", {15'd0, err}, 16'd1);
      tick();
      check("back_ready", {15'd0, op_ready}, 16'd1);
      check("back_err_hold2", {15'd0, err}, 16'd1);

      // REPEAT 3: three inc pulses, then one SETTLE cycle.
      send(3'd4, 16'h0003, 16'h0000);
      tick();
      op_valid = 1'b0;
      check("rpt3_inc1", {15'd0, inc}, 16'd1);
      tick();
      check("rpt3_inc2", {15'd0, inc}, 16'd1);
      tick();
      check("rpt3_inc3", {15'd0, inc}, 16'd1);
      check("rpt3_ready_busy", {15'd0, op_ready}, 16'd0);
      tick();
      check("rpt3_settle_inc", {15'd0, inc}, 16'd0);
      check("rpt3_settle_ready", {15'd0, op_ready}, 16'd0);
      tick();
      check("rpt3_ready", {15'd0, op_ready}, 16'd1);

      // REPEAT 0 behaves as NOP: ready stays high, no pulse.
      send(3'd4, 16'h0000, 16'h0000);
      tick();
      check("rpt0_inc1", {15'd0, inc}, 16'd0);
      check("rpt0_ready1", {15'd0, op_ready}, 16'd1);
      tick();
      op_valid = 1'b0;
      check("rpt0_inc2", {15'd0, inc}, 16'd0);
      check("rpt0_ready2", {15'd0, op_ready}, 16'd1);

      // Reset mid-REPEAT drops the pulse before any clock edge.
      send(3'd4, 16'h0005, 16'h0000);
      tick();
      op_valid = 1'b0;
      check("rptrst_inc_pre", {15'd0, inc}, 16'd1);
      #2 reset = 1'b0;
      #1;
      check("rptrst_inc_async", {15'd0, inc}, 16'd0);
      check("rptrst_err_async", {15'd0, err}, 16'd0);
      reset = 1'b1;
      tick();
      check("rptrst_ready", {15'd0, op_ready}, 16'd1);
      check("rptrst_inc_post", {15'd0, inc}, 16'd0);

      // FWD overflow boundary: 0xFF5A+0xA5 = 0xFFFF fits, 0xFF5B overflows.
      send(3'd2, 16'h00A5, 16'hFF5A);
      tick();
      op_valid = 1'b0;
      check("fwd_edge_err", {15'd0, err}, 16'd0);
      tick();
      tick();
      send(3'd2, 16'h00A5, 16'hFF5B);
      tick();
      op_valid = 1'b0;
      check("fwd_ovf_add", {15'd0, add}, 16'd1);
      check("fwd_ovf_offset", offset, 16'h00A5);
      check("fwd_ovf_err", {15'd0, err}, 16'd1);
      tick();
      tick();

      // Fresh reset so err starts clear for the CALL/RET section.
      reset = 1'b0;
      #2 reset = 1'b1;
      tick();
      check("rst2_err", {15'd0, err}, 16'd0);
      check("rst2_ready", {15'd0, op_ready}, 16'd1);

`ifdef PC_SEQ_CALL_EN
      // CALL 0x20 at pc=5 pushes 6; RET at pc=0x25 subtracts 0x1F.
      send(3'd6, 16'h0020, 16'h0005);
      tick();
      op_valid = 1'b0;
      check("call_add", {15'd0, add}, 16'd1);
      check("call_offset", offset, 16'h0020);
      check("call_err", {15'd0, err}, 16'd0);
      tick();
      tick();
      send(3'd7, 16'h0000, 16'h0025);
      tick();
      op_valid = 1'b0;
      check("ret_sub", {15'd0, sub}, 16'd1);
      check("ret_add", {15'd0, add}, 16'd0);
      check("ret_offset", offset, 16'h001F);
      check("ret_err", {15'd0, err}, 16'd0);
      tick();
      tick();
      // RET on empty stack: err, no pulse, stays IDLE.
      send(3'd7, 16'h0000, 16'h0025);
      tick();
      op_valid = 1'b0;
      check("ret_empty_err", {15'd0, err}, 16'd1);
      check("ret_empty_sub", {15'd0, sub}, 16'd0);
      check("ret_empty_ready", {15'd0, op_ready}, 16'd1);
`else
      // Without the stack, CALL sets err and acts as NOP.
      send(3'd6, 16'h0020, 16'h0005);
      tick();
      op_valid = 1'b0;
      check("call_dis_err", {15'd0, err}, 16'd1);
      check("call_dis_add", {15'd0, add}, 16'd0);
      check("call_dis_ready", {15'd0, op_ready}, 16'd1);
`endif

      // HALT, then STEP held valid: no further pulses, ready stays low.
      send(3'd5, 16'h0000, 16'h0000);
      tick();
      check("halt_halted", {15'd0, halted}, 16'd1);
      check("halt_ready", {15'd0, op_ready}, 16'd0);
      send(3'd1, 16'h0000, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("halt_no_inc", {15'd0, inc}, 16'd0);
         check("halt_ready_low", {15'd0, op_ready}, 16'd0);
      end
      check("halt_still", {15'd0, halted}, 16'd1);
      op_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
